activation_pipe: RTL and testbench

Multi-channel, fully pipelined fixed-point activation unit with valid/ready flow control. It is the next generation of the single-channel registered activation core. It applies NONE / RELU / LEAKY_RELU / CLAMP per beat to NUM_CHANNELS signed lanes. Per-channel results are rounded and saturated. It sits between the systolic array output drain and the feature writeback path, and it absorbs writeback backpressure without dropping beats.

---
 rtl/activation_pipe_pkg.sv | 16 +
 rtl/activation_pipe_lane.sv | 69 ++++++
 rtl/activation_pipe.sv | 128 ++++++++++++
 tb/tb_activation_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/activation_pipe_pkg.sv
// Shared types and defaults for the activation pipeline.
//   ACTIVATION_MODE_e  : per-beat activation selector
//   DEFAULT_*          : default Q-format geometry used by the pipeline modules
package activation_pipe_pkg;

  typedef enum logic [1:0] {
    NONE       = 2'd0,
    RELU       = 2'd1,
    LEAKY_RELU = 2'd2,
    CLAMP      = 2'd3
  } ACTIVATION_MODE_e;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_FRAC_WIDTH = 8;

endpackage

// File: rtl/activation_pipe_lane.sv
// activation_lane: combinational second-stage logic for one lane.
// Rounds and saturates the precomputed leaky product, then selects the
// activation result for the beat's mode and applies the lane mask.
//   mode      : activation mode carried with the beat
//   x         : signed input feature
//   prod      : full-width x*alpha product registered in the first stage
//   clamp_max : signed CLAMP upper bound carried with the beat
//   active    : lane mask bit (0 forces the output to zero)
//   y         : activated lane value
module activation_lane
  import activation_pipe_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int FRAC_WIDTH  = DEFAULT_FRAC_WIDTH,
  parameter int ALPHA_WIDTH = 16
) (
  input  logic [$bits(ACTIVATION_MODE_e)-1:0]     mode,
  input  logic signed [DATA_WIDTH-1:0]             x,
  input  logic signed [DATA_WIDTH+ALPHA_WIDTH-1:0] prod,
  input  logic signed [DATA_WIDTH-1:0]             clamp_max,
  input  logic                                     active,
  output logic signed [DATA_WIDTH-1:0]             y
);

  localparam int PW = DATA_WIDTH + ALPHA_WIDTH;

  // One guard bit above the product keeps the rounding add from overflowing.
  localparam logic signed [PW:0] ROUND_BIAS = (PW+1)'(1) << (FRAC_WIDTH-1);
  localparam logic signed [PW:0] SAT_MAX    = ((PW+1)'(1) << (DATA_WIDTH-1)) - (PW+1)'(1);
  localparam logic signed [PW:0] SAT_MIN    = -SAT_MAX - (PW+1)'(1);

  logic signed [PW:0]         rounded;
  logic signed [DATA_WIDTH-1:0] leaky;

  // Round half up, then saturate back into the feature range.
  always_comb begin
    rounded = ($signed({prod[PW-1], prod}) + ROUND_BIAS) >>> FRAC_WIDTH;
    if (rounded > SAT_MAX) begin
      leaky = SAT_MAX[DATA_WIDTH-1:0];
    end else if (rounded < SAT_MIN) begin
      leaky = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      leaky = rounded[DATA_WIDTH-1:0];
    end
  end

  // A negative clamp bound yields zero; any unlisted encoding passes x through.
  always_comb begin
    y = x;
    case (ACTIVATION_MODE_e'(mode))
      RELU:       y = x[DATA_WIDTH-1] ? '0 : x;
      LEAKY_RELU: y = x[DATA_WIDTH-1] ? leaky : x;
      CLAMP: begin
        if (clamp_max[DATA_WIDTH-1] || x[DATA_WIDTH-1]) begin
          y = '0;
        end else if (x > clamp_max) begin
          y = clamp_max;
        end else begin
          y = x;
        end
      end
      default:    y = x;
    endcase
    if (!active) begin
      y = '0;
    end
  end

endmodule

// File: rtl/activation_pipe.sv
// activation_pipe: multi-lane, two-stage fixed-point activation unit with
// valid/ready flow control.
//   core_clk, resetn          : clock, asynchronous active-low reset
//   sel_activation            : activation mode sampled with each accepted beat
//   cfg_leaky_alpha           : signed leaky-ReLU slope (Q format)
//   cfg_clamp_max             : signed CLAMP upper bound
//   cfg_channel_mask          : per-lane enable, disabled lanes output zero
//   in_valid/in_ready         : input handshake, in_feature lanes packed LSB first
//   out_valid/out_ready       : output handshake, out_feature same packing
//   beat_count, count_clear   : output handshake counter and its synchronous clear
// Stage 1 registers the operands and the lane products; stage 2 registers the
// rounded, saturated and selected result that drives the outputs.
module activation_pipe
  import activation_pipe_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int FRAC_WIDTH   = DEFAULT_FRAC_WIDTH,
  parameter int ALPHA_WIDTH  = 16,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                                 core_clk,
  input  logic                                 resetn,
  input  logic [$bits(ACTIVATION_MODE_e)-1:0]  sel_activation,
  input  logic [ALPHA_WIDTH-1:0]               cfg_leaky_alpha,
  input  logic [DATA_WIDTH-1:0]                cfg_clamp_max,
  input  logic [NUM_CHANNELS-1:0]              cfg_channel_mask,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   in_feature,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   out_feature,
  output logic [COUNT_WIDTH-1:0]               beat_count,
  input  logic                                 count_clear
);

  localparam int MW = $bits(ACTIVATION_MODE_e);
  localparam int PW = DATA_WIDTH + ALPHA_WIDTH;

  logic                               s1_valid;
  logic [MW-1:0]                      s1_mode;
  logic [DATA_WIDTH-1:0]              s1_clamp;
  logic [NUM_CHANNELS-1:0]            s1_mask;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] s1_x;
  logic signed [PW-1:0]               s1_prod [NUM_CHANNELS];

  logic                               s2_valid;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] s2_feature;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] lane_y;

  logic adv1;
  logic adv2;

  // A stage may advance when it is empty or its successor is advancing,
  // so full throughput holds with no skid buffer.
  assign adv2     = !s2_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  // Config travels with the beat; the multiply sits here so it can map to DSP registers.
  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_mode  <= '0;
      s1_clamp <= '0;
      s1_mask  <= '0;
      s1_x     <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        s1_prod[i] <= '0;
      end
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode  <= sel_activation;
        s1_clamp <= cfg_clamp_max;
        s1_mask  <= cfg_channel_mask;
        s1_x     <= in_feature;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
          s1_prod[i] <= $signed(in_feature[i*DATA_WIDTH +: DATA_WIDTH]) * $signed(cfg_leaky_alpha);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_lane
    activation_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_WIDTH (FRAC_WIDTH),
      .ALPHA_WIDTH(ALPHA_WIDTH)
    ) u_lane (
      .mode     (s1_mode),
      .x        (s1_x[g*DATA_WIDTH +: DATA_WIDTH]),
      .prod     (s1_prod[g]),
      .clamp_max(s1_clamp),
      .active   (s1_mask[g]),
      .y        (lane_y[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Output data only changes when a real beat moves in, so it holds while stalled.
  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      s2_valid   <= 1'b0;
      s2_feature <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_feature <= lane_y;
      end
    end
  end

  assign out_valid   = s2_valid;
  assign out_feature = s2_feature;

  // Clear takes priority over a coincident handshake.
  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      beat_count <= '0;
    end else if (count_clear) begin
      beat_count <= '0;
    end else if (out_valid && out_ready) begin
      beat_count <= beat_count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_activation_pipe.sv
// Directed testbench for activation_pipe (4 lanes, Q8.8 features and alpha).
module tb_activation_pipe;

  logic        core_clk;
  logic        resetn;
  logic [1:0]  sel_activation;
  logic [15:0] cfg_leaky_alpha;
  logic [15:0] cfg_clamp_max;
  logic [3:0]  cfg_channel_mask;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_feature;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_feature;
  logic [31:0] beat_count;
  logic        count_clear;

  int checks = 0;
  int errors = 0;

  activation_pipe dut (
    .core_clk        (core_clk),
    .resetn          (resetn),
    .sel_activation  (sel_activation),
    .cfg_leaky_alpha (cfg_leaky_alpha),
    .cfg_clamp_max   (cfg_clamp_max),
    .cfg_channel_mask(cfg_channel_mask),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_feature      (in_feature),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_feature     (out_feature),
    .beat_count      (beat_count),
    .count_clear     (count_clear)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input logic [15:0] alpha,
                               input logic [15:0] cmax, input logic [3:0] mask,
                               input logic [63:0] feat);
    sel_activation   = mode;
    cfg_leaky_alpha  = alpha;
    cfg_clamp_max    = cmax;
    cfg_channel_mask = mask;
    in_feature       = feat;
    in_valid         = 1'b1;
  endtask

  // One isolated beat with out_ready high: checks latency, value and drain.
  task automatic runSingle(input string tag, input logic [1:0] mode, input logic [15:0] alpha,
                           input logic [15:0] cmax, input logic [3:0] mask,
                           input logic [63:0] feat, input logic [63:0] expected);
    out_ready = 1'b1;
    applyStimulus(mode, alpha, cmax, mask, feat);
    @(posedge core_clk); #1;
    in_valid = 1'b0;
    checkOutput({tag, "_lat1"}, 64'(out_valid), 64'd0);
    @(posedge core_clk); #1;
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
    checkOutput(tag, out_feature, expected);
    @(posedge core_clk); #1;
    checkOutput({tag, "_drain"}, 64'(out_valid), 64'd0);
  endtask

  function automatic logic [15:0] laneVal(input int k, input int i);
    return 16'(k * 4660 + i * 17185);
  endfunction

  // Odd beats use RELU, even beats NONE.
  function automatic logic [63:0] bpExpect(input int k);
    logic [63:0] r;
    logic [15:0] x;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      x = laneVal(k, i);
      if ((k % 2 == 1) && x[15]) x = 16'h0000;
      r[i*16 +: 16] = x;
    end
    return r;
  endfunction

  function automatic logic [63:0] bpFeature(input int k);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = laneVal(k, i);
    return r;
  endfunction

  initial begin
    logic [63:0] expq[$];
    logic [63:0] held;
    logic [63:0] front;
    logic        stalled;
    int          sent;
    int          recv;
    int          cyc;

    resetn = 1'b0;
    sel_activation = 2'd0;
    cfg_leaky_alpha = '0;
    cfg_clamp_max = '0;
    cfg_channel_mask = '0;
    in_valid = 1'b0;
    in_feature = '0;
    out_ready = 1'b0;
    count_clear = 1'b0;
    #12;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_feature", out_feature, 64'd0);
    checkOutput("reset_beat_count", 64'(beat_count), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge core_clk); #1;
    resetn = 1'b1;
    @(posedge core_clk); #1;

    $display("[TB] leaky relu / rounding / saturation");
    runSingle("leaky_a20", 2'd2, 16'h0020, 16'h0000, 4'b1111,
              {16'h0000, 16'hFFFF, 16'h0300, 16'hFE00}, {16'h0000, 16'h0000, 16'h0300, 16'hFFC0});
    runSingle("leaky_sat", 2'd2, 16'h7FFF, 16'h0000, 4'b1111,
              {16'h0001, 16'hFF00, 16'h7FFF, 16'h8000}, {16'h0001, 16'h8001, 16'h7FFF, 16'h8000});
    runSingle("leaky_round", 2'd2, 16'h0080, 16'h0000, 4'b1111,
              {16'h0000, 16'hFF00, 16'hFFFE, 16'hFFFF}, {16'h0000, 16'hFF80, 16'hFFFF, 16'h0000});
    runSingle("leaky_mask", 2'd2, 16'h0020, 16'h0000, 4'b0110,
              {16'h0000, 16'hFFFF, 16'h0300, 16'hFE00}, {16'h0000, 16'h0000, 16'h0300, 16'h0000});

    $display("[TB] clamp / relu / none");
    runSingle("clamp", 2'd3, 16'h0000, 16'h0600, 4'b1111,
              {16'h0600, 16'hFF00, 16'h0280, 16'h0700}, {16'h0600, 16'h0000, 16'h0280, 16'h0600});
    runSingle("clamp_mask", 2'd3, 16'h0000, 16'h0600, 4'b1010,
              {16'h0600, 16'hFF00, 16'h0280, 16'h0700}, {16'h0600, 16'h0000, 16'h0280, 16'h0000});
    runSingle("clamp_neg_max", 2'd3, 16'h0000, 16'hFFF0, 4'b1111,
              {16'h0100, 16'hFFF0, 16'h0000, 16'h7FFF}, 64'd0);
    runSingle("relu", 2'd1, 16'h0000, 16'h0000, 4'b1111,
              {16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF}, {16'h0000, 16'h7FFF, 16'h0001, 16'h0000});
    runSingle("none", 2'd0, 16'h0000, 16'h0000, 4'b1111,
              {16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF}, {16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF});
    runSingle("none_masked", 2'd0, 16'h0000, 16'h0000, 4'b0000,
              {16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF}, 64'd0);

    $display("[TB] mode switch on consecutive beats");
    out_ready = 1'b1;
    applyStimulus(2'd1, 16'h0000, 16'h0000, 4'b1111, {4{16'hFF00}});
    @(posedge core_clk); #1;
    applyStimulus(2'd0, 16'h0000, 16'h0000, 4'b1111, {4{16'hFF00}});
    @(posedge core_clk); #1;
    in_valid = 1'b0;
    checkOutput("switch_a_valid", 64'(out_valid), 64'd1);
    checkOutput("switch_a", out_feature, 64'd0);
    @(posedge core_clk); #1;
    checkOutput("switch_b_valid", 64'(out_valid), 64'd1);
    checkOutput("switch_b", out_feature, {4{16'hFF00}});
    @(posedge core_clk); #1;

    $display("[TB] backpressure stream");
    count_clear = 1'b1;
    @(posedge core_clk); #1;
    count_clear = 1'b0;
    checkOutput("bp_cleared", 64'(beat_count), 64'd0);
    sent = 0;
    recv = 0;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    while (recv < 10 && cyc < 200) begin
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (sent < 10) begin
        applyStimulus((sent % 2 == 1) ? 2'd1 : 2'd0, 16'h0000, 16'h0000, 4'b1111, bpFeature(sent));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stalled) begin
        checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
        checkOutput("bp_hold_data", out_feature, held);
      end
      checkOutput("bp_in_ready", 64'(in_ready), 64'(!((sent - recv) == 2 && !out_ready)));
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checkOutput("bp_spurious_beat", 64'(out_valid), 64'd0);
        end else begin
          front = expq.pop_front();
          checkOutput("bp_data", out_feature, front);
        end
        recv++;
      end
      stalled = out_valid && !out_ready;
      held = out_feature;
      if (in_valid && in_ready) begin
        expq.push_back(bpExpect(sent));
        sent++;
      end
      @(posedge core_clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checkOutput("bp_received", 64'(recv), 64'd10);
    checkOutput("bp_beat_count", 64'(beat_count), 64'd10);

    $display("[TB] reset with beats in flight");
    out_ready = 1'b0;
    applyStimulus(2'd0, 16'h0000, 16'h0000, 4'b1111, {4{16'h1111}});
    @(posedge core_clk); #1;
    applyStimulus(2'd0, 16'h0000, 16'h0000, 4'b1111, {4{16'h2222}});
    @(posedge core_clk); #1;
    in_valid = 1'b0;
    checkOutput("rst_pre_valid", 64'(out_valid), 64'd1);
    checkOutput("rst_pre_ready", 64'(in_ready), 64'd0);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_feature", out_feature, 64'd0);
    checkOutput("rst_beat_count", 64'(beat_count), 64'd0);
    @(posedge core_clk); #1;
    resetn = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge core_clk); #1;
      checkOutput("rst_no_stale", 64'(out_valid), 64'd0);
    end

    $display("[TB] count clear coincident with handshake");
    runSingle("post_rst_clamp", 2'd3, 16'h0000, 16'h0600, 4'b1010,
              {16'h0600, 16'hFF00, 16'h0280, 16'h0700}, {16'h0600, 16'h0000, 16'h0280, 16'h0000});
    checkOutput("count_one", 64'(beat_count), 64'd1);
    applyStimulus(2'd0, 16'h0000, 16'h0000, 4'b1111, {4{16'h0123}});
    @(posedge core_clk); #1;
    in_valid = 1'b0;
    @(posedge core_clk); #1;
    checkOutput("clr_valid", 64'(out_valid), 64'd1);
    checkOutput("clr_before", 64'(beat_count), 64'd1);
    count_clear = 1'b1;
    @(posedge core_clk); #1;
    count_clear = 1'b0;
    checkOutput("clr_wins", 64'(beat_count), 64'd0);
    checkOutput("clr_drained", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
